// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN / PAUSED / ADJUST sequencing, MM:SS BCD count
// register and adjust-mode blink blanking for the display driver.
module stopwatch_ctrl (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_4hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FIELD_W = 2 * DIGIT_W;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  // {carry, tens, ones} for a 00..59 BCD field incremented by one
  function automatic logic [FIELD_W:0] bcd_inc(input logic [DIGIT_W-1:0] tens,
                                               input logic [DIGIT_W-1:0] ones);
    logic [DIGIT_W-1:0] t;
    logic [DIGIT_W-1:0] o;
    logic               c;
    t = tens;
    o = ones;
    c = 1'b0;
    if (ones >= DIGIT_W'(9)) begin
      o = '0;
      if (tens >= DIGIT_W'(5)) begin
        t = '0;
        c = 1'b1;
      end else begin
        t = tens + DIGIT_W'(1);
      end
    end else begin
      o = ones + DIGIT_W'(1);
    end
    return {c, t, o};
  endfunction

  logic   adj_m, adj_s, sel_m, sel_s;
  logic   paused, paused_d;
  logic   phase, phase_d;
  state_t state, state_d;
  logic   running_d, blank_min_d, blank_sec_d;

  logic [FIELD_W:0]   sec_inc, min_inc;
  logic [FIELD_W-1:0] sec_d, min_d;

  // Two-flop synchronizers for the raw switches
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      adj_m <= 1'b0;
      adj_s <= 1'b0;
      sel_m <= 1'b0;
      sel_s <= 1'b0;
    end else begin
      adj_m <= sw_adj;
      adj_s <= adj_m;
      sel_m <= sw_sel;
      sel_s <= sel_m;
    end
  end

  // State register
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_PAUSED;
      paused <= 1'b1;
    end else begin
      state  <= state_d;
      paused <= paused_d;
    end
  end

  // Next state tracks the next synchronized switch value so state always equals the decode of adj_s/paused
  always_comb begin
    paused_d = paused;
    state_d  = state;
    if (btn_pause && !adj_s) begin
      paused_d = ~paused;
    end
    if (adj_m) begin
      state_d = ST_ADJUST;
    end else if (paused_d) begin
      state_d = ST_PAUSED;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output decode and blink phase; phase restarts low on every select change
  always_comb begin
    phase_d     = phase;
    running_d   = 1'b0;
    blank_min_d = 1'b0;
    blank_sec_d = 1'b0;
    if (state_d != ST_ADJUST || sel_m != sel_s) begin
      phase_d = 1'b0;
    end else if (state == ST_ADJUST && tick_4hz) begin
      phase_d = ~phase;
    end
    running_d   = (state_d == ST_RUN);
    blank_min_d = (state_d == ST_ADJUST) && !sel_m && phase_d;
    blank_sec_d = (state_d == ST_ADJUST) && sel_m && phase_d;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      running   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      phase     <= phase_d;
      running   <= running_d;
      blank_min <= blank_min_d;
      blank_sec <= blank_sec_d;
    end
  end

  assign sec_inc = bcd_inc(sec_tens, sec_ones);
  assign min_inc = bcd_inc(min_tens, min_ones);

  // Count datapath: reset button beats any increment in the same cycle
  always_comb begin
    sec_d = {sec_tens, sec_ones};
    min_d = {min_tens, min_ones};
    if (btn_reset) begin
      sec_d = '0;
      min_d = '0;
    end else if (state == ST_RUN && tick_1hz) begin
      sec_d = sec_inc[FIELD_W-1:0];
      if (sec_inc[FIELD_W]) begin
        min_d = min_inc[FIELD_W-1:0];
      end
    end else if (state == ST_ADJUST && tick_2hz) begin
      if (sel_s) begin
        sec_d = sec_inc[FIELD_W-1:0];
      end else begin
        min_d = min_inc[FIELD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      {min_tens, min_ones} <= min_d;
      {sec_tens, sec_ones} <= sec_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model queues the expected
// outputs for every clock and they are compared once the edge has passed.
module tb_stopwatch_ctrl;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_4hz = 1'b0;
  logic       btn_pause = 1'b0, btn_reset = 1'b0;
  logic       sw_adj = 1'b0, sw_sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       blank_min, blank_sec, running;

  int n_vec = 0;
  int n_err = 0;

  logic [18:0] sb_q[$];

  // Behavioural model state
  int m_min, m_sec;
  bit m_paused, m_adj1, m_adj2, m_sel1, m_sel2, m_phase;

  stopwatch_ctrl dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_4hz(tick_4hz),
    .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  function automatic logic [18:0] dut_vec();
    return {min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running};
  endfunction

  function automatic logic [15:0] mmss();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_min = 0; m_sec = 0;
    m_paused = 1'b1;
    m_adj1 = 1'b0; m_adj2 = 1'b0; m_sel1 = 1'b0; m_sel2 = 1'b0;
    m_phase = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive pulses, predict, advance, compare; switches keep their current level
  task automatic step(input bit t1, input bit t2, input bit t4, input bit bp, input bit br);
    int st, nst;
    bit sel_before;
    logic [18:0] exp;
    tick_1hz = t1; tick_2hz = t2; tick_4hz = t4; btn_pause = bp; btn_reset = br;
    st = m_adj2 ? 2 : (m_paused ? 0 : 1);
    sel_before = m_sel2;
    if (br) begin
      m_min = 0; m_sec = 0;
    end else if (st == 1 && t1) begin
      m_sec = m_sec + 1;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = (m_min + 1) % 60;
      end
    end else if (st == 2 && t2) begin
      if (m_sel2) m_sec = (m_sec + 1) % 60;
      else        m_min = (m_min + 1) % 60;
    end
    if (bp && !m_adj2) m_paused = !m_paused;
    m_adj2 = m_adj1; m_adj1 = sw_adj;
    m_sel2 = m_sel1; m_sel1 = sw_sel;
    nst = m_adj2 ? 2 : (m_paused ? 0 : 1);
    if (nst != 2 || m_sel2 != sel_before) m_phase = 1'b0;
    else if (st == 2 && t4) m_phase = !m_phase;
    exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
           (nst == 2) && !m_sel2 && m_phase, (nst == 2) && m_sel2 && m_phase, nst == 1};
    sb_q.push_back(exp);
    @(posedge clk_100mhz);
    #1;
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0; btn_pause = 1'b0; btn_reset = 1'b0;
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("cycle", 32'(dut_vec()), 32'(sb_q.pop_front()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_100mhz);
    #1;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;

    // Start, count 61 s, then pause and confirm ticks are ignored
    step(0, 0, 0, 1, 0);
    chk("running_after_start", 32'(running), 32'd1);
    for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0);
    chk("count_61", 32'(mmss()), 32'h0101);
    chk("running_61", 32'(running), 32'd1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("paused_hold", 32'(mmss()), 32'h0101);
    chk("paused_running", 32'(running), 32'd0);

    // Preload 59:59 through adjust, then run one tick to wrap
    sw_adj = 1'b1; sw_sel = 1'b0;
    idle(3);
    for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0);
    sw_sel = 1'b1;
    idle(3);
    for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0);
    chk("preload_5959", 32'(mmss()), 32'h5959);
    sw_adj = 1'b0;
    idle(3);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("wrap_0000", 32'(mmss()), 32'h0000);
    chk("wrap_running", 32'(running), 32'd1);

    // Adjust seconds across 59 -> 00 without carry, then minutes
    sw_adj = 1'b1; sw_sel = 1'b1;
    idle(3);
    for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("adj_sec_wrap", 32'(mmss()), 32'h0001);
    sw_sel = 1'b0;
    idle(3);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("adj_min", 32'(mmss()), 32'h0201);

    // Blink on the minutes field
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("blink_min", 32'(blank_min), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("blink_sec", 32'(blank_sec), 32'd0);
    end
    step(0, 0, 1, 0, 0);
    sw_adj = 1'b0;
    idle(3);
    chk("blank_exit", 32'({blank_min, blank_sec}), 32'd0);
    chk("exit_to_run", 32'(running), 32'd1);

    // Reset button wins over a coincident tick
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    chk("count_0010", 32'(mmss()), 32'h0010);
    step(1, 0, 0, 0, 1);
    chk("reset_vs_tick", 32'(mmss()), 32'h0000);
    chk("reset_keeps_run", 32'(running), 32'd1);

    // Pause with tick counts; resume with tick does not
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("pause_tick_count", 32'(mmss()), 32'h0004);
    chk("pause_tick_running", 32'(running), 32'd0);
    step(1, 0, 0, 1, 0);
    chk("resume_tick_count", 32'(mmss()), 32'h0004);
    chk("resume_running", 32'(running), 32'd1);

    // Random mix of ticks, buttons and switch changes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) sw_adj = !sw_adj;
      if ($urandom_range(0, 19) == 0) sw_sel = !sw_sel;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset in the middle of counting
    sw_adj = 1'b0; sw_sel = 1'b0;
    idle(3);
    if (m_paused) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("pre_async_count", 32'(mmss()), 32'h0005);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    chk("post_reset_paused", 32'({mmss(), running}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller and time-of-count register for the Lab 3 stopwatch. Consumes the one-cycle tick enables from the clock divider (1 Hz, 2 Hz, 4 Hz), the debounced button pulses and the raw adjust/select switches. Sequences RUN / PAUSED / ADJUST behaviour and holds the MM:SS count as four BCD digits for the display driver. Also produces per-field blank controls for the adjust-mode blink.

## Interface
- No parameters. Tick rates come from the divider; the block is rate-agnostic.
- clk_100mhz  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle count enable, clk_100mhz domain
- tick_2hz  in  1  one-cycle adjust-increment enable
- tick_4hz  in  1  one-cycle blink-toggle enable
- btn_pause  in  1  one-cycle debounced pulse; toggles run/pause
- btn_reset  in  1  one-cycle debounced pulse; clears count to 00:00
- sw_adj  in  1  raw switch, asynchronous; 1 = adjust mode
- sw_sel  in  1  raw switch, asynchronous; adjust target: 0 = minutes, 1 = seconds
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD count digits, registered
- blank_min, blank_sec  out  1 each  1 = display driver blanks that field
- running  out  1  1 while state is RUN

## Operation
- sw_adj and sw_sel each pass through a 2-flop synchronizer; only the synchronized values (adj_s, sel_s) are used.
- Internal paused flag. btn_pause toggles it only when adj_s = 0; it is ignored in ADJUST.
- State is derived from adj_s and paused:
  - ADJUST if adj_s = 1
  - else PAUSED if paused = 1
  - else RUN
  - Leaving ADJUST returns to RUN or PAUSED according to the unchanged paused flag.
- RUN: on tick_1hz, SS increments.
  - sec_ones 9→0 carries to sec_tens.
  - sec_tens 5→0 carries to minutes.
  - Minutes follow the same 0-59 BCD rule.
  - 59:59 wraps to 00:00.
- PAUSED: count holds; ticks are ignored.
- ADJUST: on tick_2hz, the selected field increments 00..59 with wrap 59→00.
  - No carry into or out of the other field.
  - The other field holds. tick_1hz is ignored.
- Blink phase register: toggles on tick_4hz while in ADJUST.
  - Forced to 0 outside ADJUST and for one cycle whenever sel_s changes.
  - blank_min = ADJUST & ~sel_s & phase; blank_sec = ADJUST & sel_s & phase.
- btn_reset: digits go to 00:00 in any state. State and paused flag are unchanged.
- Priority within one cycle: btn_reset > count/adjust increment. An increment coincident with reset is discarded.
- btn_pause coincident with tick_1hz in RUN: the tick is applied; the pause takes effect from the next cycle. Resuming from PAUSED with a coincident tick: the tick is not counted.
- Digits never leave the BCD range 0-9 and never exceed 59 per field. An illegal value cannot be produced from reset.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - digits = 0
  - paused = 1, so state is PAUSED and running = 0
  - phase = 0, so blank_min = blank_sec = 0
  - synchronizer flops = 0
- Release of rst_n is synchronous in effect; the first update is on the first rising edge with rst_n high.
- Count and digit outputs update on the rising edge where the enable is sampled high, i.e. visible one cycle after the tick.
- btn_pause changes running on the edge that samples it.
- sw_adj or sw_sel change to effect: 2 synchronizer edges, then the state/decode is in effect. An increment can be affected starting the 3rd edge after the switch change meets setup.
- Reset asserted mid-ADJUST or mid-count: immediate clear of all outputs. No partial digit update survives.
- All outputs are registered or decoded only from registers; there is no combinational path from the tick or button inputs to the outputs.

## Test plan
- Reset, pulse btn_pause, apply 61 tick_1hz pulses → digits 01:01, running = 1. Pulse btn_pause, apply 5 ticks → still 01:01, running = 0.
- Preload via adjust to 59:59, leave adjust, RUN, one tick_1hz → 00:00 the next cycle.
- sw_adj = 1, sw_sel = 1, count at 00:58, apply 3 tick_2hz → 00:01 with minutes unchanged. sw_sel = 0, apply 2 tick_2hz → 02:01.
- In ADJUST with sel = minutes, apply 4 tick_4hz → blank_min toggles 1,0,1,0 and blank_sec stays 0. sw_adj = 0 → both 0 within 3 cycles.
- RUN at 00:10, btn_reset and tick_1hz in the same cycle → 00:00, running stays 1.
- btn_pause and tick_1hz in the same cycle in RUN → count +1, running = 0 next cycle. Drop rst_n mid-count → all outputs at reset values immediately, without waiting for a clock edge.
